// File: rtl/raizing_snd_pkg.sv
// Shared definitions for the Raizing sound mailbox: the byte returned on an
// empty pop, the interrupt FSM state encoding and the channel-index width helper.
package raizing_snd_pkg;

  localparam logic [7:0] MBOX_EMPTY_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    INT_IDLE  = 2'd0,
    INT_REQ   = 2'd1,
    INT_ACKED = 2'd2
  } int_state_t;

  // Channel select width; a single channel still gets a 1-bit select.
  function automatic int chw_of(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/raizing_mbox_fifo.sv
// One mailbox command channel: DEPTH x DW circular FIFO.
// A push is accepted when the channel is not full, or when it is full and a
// pop happens in the same cycle (count unchanged). A pop only takes effect on a
// non-empty channel, so push+pop on an empty channel stores the byte and the
// pop side sees "empty" (no bypass). head is the combinational head entry.
module raizing_mbox_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          nempty,
  output logic          accepted,
  output logic          dropped
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign nempty   = (count != '0);
  assign do_pop   = pop && nempty;
  assign do_push  = push && (!full || do_pop);
  assign accepted = do_push;
  assign dropped  = push && !do_push;
  assign head     = mem[rd_ptr];

  // Storage array; flushing is done by resetting the pointers, not the data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally mod DEPTH (power of 2); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/raizing_snd_mailbox.sv
// 68k -> Z80 command mailbox: NCH command FIFOs, one Z80 -> 68k reply
// register, a 68k wait flag and Z80 INT generation with IM1 acknowledge.
// Optional macro RAIZING_MBOX_REARM_EN: the INT FSM also re-arms from IDLE
// while any channel still holds data; without it only a new accepted write
// raises INT.
// Handshake: all *_WR, *_RD, *_ACK inputs are single-cycle strobes from the
// bus decoders; an operation happens in the cycle the strobe is high and its
// effect is visible on the outputs from the next cycle.
module raizing_snd_mailbox
  import raizing_snd_pkg::*;
#(
  parameter int  NCH   = 2,
  parameter int  DEPTH = 4,
  parameter int  DW    = 8,
  localparam int CHW   = chw_of(NCH)
) (
  input  logic           CLK96,
  input  logic           RESET96,
  input  logic           M68_WR,
  input  logic [CHW-1:0] M68_CH,
  input  logic [DW-1:0]  M68_DIN,
  output logic           M68_WAIT,
  output logic [NCH-1:0] M68_FULL,
  output logic           M68_OVF,
  output logic [DW-1:0]  M68_REPLY,
  output logic           M68_REPLY_VLD,
  input  logic           M68_REPLY_RD,
  input  logic           Z80_RD,
  input  logic [CHW-1:0] Z80_RD_CH,
  output logic [DW-1:0]  Z80_DOUT,
  input  logic           Z80_ACK,
  input  logic           Z80_REPLY_WR,
  input  logic [DW-1:0]  Z80_REPLY_DIN,
  output logic [NCH-1:0] Z80_STATUS,
  input  logic           IORQ_N,
  input  logic           M1_N,
  output logic           INT_N,
  output logic [1:0]     DBG_INT_STATE
);

  localparam logic [DW-1:0] EMPTY_WORD = DW'(MBOX_EMPTY_BYTE);

  logic [NCH-1:0] acc_v;
  logic [NCH-1:0] drop_v;
  logic [DW-1:0]  heads [NCH];
  logic           wr_accepted;
  logic           rearm;
  logic [DW-1:0]  rd_word;
  int_state_t     state, state_nxt;
  logic           pending, pending_nxt;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    raizing_mbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clk      (CLK96),
      .rst      (RESET96),
      .push     (M68_WR && (M68_CH == CHW'(c))),
      .din      (M68_DIN),
      .pop      (Z80_RD && (Z80_RD_CH == CHW'(c))),
      .head     (heads[c]),
      .full     (M68_FULL[c]),
      .nempty   (Z80_STATUS[c]),
      .accepted (acc_v[c]),
      .dropped  (drop_v[c])
    );
  end

  assign wr_accepted = |acc_v;

`ifdef RAIZING_MBOX_REARM_EN
  assign rearm = |Z80_STATUS;
`else
  assign rearm = 1'b0;
`endif

  // Select the byte a Z80 pop returns: head of a non-empty channel, else empty.
  always_comb begin
    rd_word = EMPTY_WORD;
    for (int c = 0; c < NCH; c++) begin
      if ((Z80_RD_CH == CHW'(c)) && Z80_STATUS[c]) rd_word = heads[c];
    end
  end

  // Registered Z80 read data; holds its value between pops.
  always_ff @(posedge CLK96) begin
    if (RESET96)     Z80_DOUT <= EMPTY_WORD;
    else if (Z80_RD) Z80_DOUT <= rd_word;
  end

  // Sticky overflow, wait flag (set beats ack) and reply (write beats read).
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      M68_OVF       <= 1'b0;
      M68_WAIT      <= 1'b0;
      M68_REPLY     <= '0;
      M68_REPLY_VLD <= 1'b0;
    end else begin
      if (|drop_v)          M68_OVF  <= 1'b1;
      if (wr_accepted)      M68_WAIT <= 1'b1;
      else if (Z80_ACK)     M68_WAIT <= 1'b0;
      if (Z80_REPLY_WR) begin
        M68_REPLY     <= Z80_REPLY_DIN;
        M68_REPLY_VLD <= 1'b1;
      end else if (M68_REPLY_RD) begin
        M68_REPLY_VLD <= 1'b0;
      end
    end
  end

  // INT FSM state and pending-write register.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state   <= INT_IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // INT FSM next state: a write seen while acknowledged is remembered so the
  // Z80 gets a fresh interrupt once the INTA cycle has finished.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      INT_IDLE: begin
        if (wr_accepted || pending || rearm) begin
          state_nxt   = INT_REQ;
          pending_nxt = 1'b0;
        end
      end
      INT_REQ: begin
        if (!IORQ_N && !M1_N) state_nxt = INT_ACKED;
      end
      INT_ACKED: begin
        if (wr_accepted) pending_nxt = 1'b1;
        if (IORQ_N)      state_nxt   = INT_IDLE;
      end
      default: state_nxt = INT_IDLE;
    endcase
  end

  assign INT_N         = (state != INT_REQ);
  assign DBG_INT_STATE = state;

endmodule
